spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI byte engine among NUM_REQ requesters. Each requester owns one active-low slave select. A requester holds the bus for a multi-byte burst, ended by its `req_last` flag. The block launches each byte on the engine, returns the received byte tagged with the requester ID, and releases the bus on burst end or on a timeout. It sits between client logic and the SPI master shift engine.

## Interface
- NUM_REQ, 4: number of requesters / slave selects (2..8)
- TIMEOUT, 64: cycles allowed for a byte handshake or an engine completion (≥2)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte to send
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_last  in  NUM_REQ  byte is the final byte of requester i's burst
- req_ready  out  NUM_REQ  combinational; only the granted bit can be 1, and only in LAUNCH
- rsp_valid  out  1  one-cycle pulse; received byte or error is available
- rsp_data  out  8  received byte; 0 on error
- rsp_id  out  $clog2(NUM_REQ)  granted requester index for the response
- rsp_err  out  1  qualifies rsp_valid; timeout occurred
- ss_n  out  NUM_REQ  slave selects, active low, at most one low at a time
- eng_start  out  1  one-cycle pulse to the shift engine
- eng_tx_data  out  8  byte to shift out; valid with eng_start
- eng_done  in  1  engine finished 8 bits
- eng_rx_data  in  8  byte shifted in; valid with eng_done
- busy  out  1  state != IDLE

## Operation
- Reset values: state IDLE, ptr=0, grant=0, ss_n all 1s, eng_start=0, eng_tx_data=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, timeout counter=0. req_ready and busy follow from state.
- Reset mid-operation: the next edge forces the reset values. No response is emitted. The engine shares the same reset.
- **IDLE**: if any req_valid is high, pick a winner by searching ptr, ptr+1, … with wrap modulo NUM_REQ. Register the winner as grant, drive ss_n[grant]=0, go to SELECT.
- **SELECT**: one setup cycle, then go to LAUNCH. Clear the counter.
- **LAUNCH**: req_ready[grant]=1.
  - If req_valid[grant] is high on the edge: latch req_data and req_last, drive eng_start=1 and eng_tx_data, clear the counter, go to WAIT.
  - Otherwise increment the counter. At TIMEOUT consecutive edges: drive rsp_valid=1, rsp_err=1, rsp_data=0, ss_n all 1s, go to RELEASE.
- **WAIT**: eng_start=0 after the first cycle.
  - On eng_done: drive rsp_valid=1, rsp_data=eng_rx_data, rsp_err=0, rsp_id=grant. If the latched last is set: ss_n all 1s, go to RELEASE. Otherwise clear the counter and go to LAUNCH; ss_n stays low.
  - Without eng_done: increment the counter. At TIMEOUT edges: drive an error response (as in LAUNCH), ss_n all 1s, go to RELEASE.
  - If eng_done and timeout fall on the same edge, eng_done wins.
- **RELEASE**: set ptr = (grant+1) mod NUM_REQ, go to IDLE.
- eng_done outside WAIT is ignored.
- Requests from non-granted requesters are ignored until the bus is released. The burst is locked to the grant.

## Timing
- Request sampled in IDLE at edge E0:
  - ss_n[g] low after E0.
  - req_ready[g] high during the cycle after E1.
  - Handshake at E2; eng_start high for exactly the cycle after E2.
- eng_done sampled at edge Ek: rsp_valid high for exactly the cycle after Ek.
- Minimum turnaround, eng_done to next burst-byte handshake: LAUNCH entered after Ek, handshake at Ek+1.
- Last byte: ss_n deasserts on the same edge that raises rsp_valid.
  - RELEASE takes 1 cycle, IDLE takes at least 1 cycle.
  - So ss_n stays high for at least 2 cycles between bursts.
- Timeout counter is $clog2(TIMEOUT+1) bits. It saturates and never wraps.
- rsp_id is held from grant until the next grant.

## Test plan
- Single requester, NUM_REQ=4: req 2 sends 0xA5 with last=1; engine returns 0x3C after 8 cycles. Required: ss_n=4'b1011 during the burst; eng_tx_data=0xA5; one rsp_valid with rsp_data=0x3C, rsp_id=2, rsp_err=0; ss_n=4'hF afterwards.
- Burst lock: req 0 sends 3 bytes (0x11, 0x22, 0x33 with last on 0x33) while req 1 requests continuously. Required: 3 responses with rsp_id=0 and ss_n[0] low throughout; req 1 granted only after at least 2 cycles with ss_n=4'hF.
- Round-robin: all 4 requesters hold single-byte requests from reset. Required: grant order 0,1,2,3,0; after wrap, ptr returns to 0.
- Engine timeout, TIMEOUT=8: eng_done never asserted. Required: rsp_valid with rsp_err=1 and rsp_data=0 on the 8th WAIT edge; ss_n=4'hF; state back to IDLE.
- Requester stall: a burst byte has last=0, then req_valid drops. Required: LAUNCH times out after TIMEOUT edges with rsp_err=1; the next requester is then granted.
- Mid-burst reset: reset asserted for one cycle while in WAIT. Required: next edge gives ss_n=4'hF, busy=0, rsp_valid=0, eng_start=0; a late eng_done produces no response.

Source files
------------

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI byte engine among NUM_REQ burst requesters
module spi_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic                       rsp_err,
    output logic [NUM_REQ-1:0]         ss_n,
    output logic                       eng_start,
    output logic [7:0]                 eng_tx_data,
    input  logic                       eng_done,
    input  logic [7:0]                 eng_rx_data,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, SELECT, LAUNCH, WAIT, RELEASE} state_t;
    state_t state;
    logic [IW-1:0] ptr, grant, win, idx;
    logic [CW-1:0] cnt;
    logic          last_q;
    logic          to;
    assign to = cnt == CW'(TIMEOUT - 1);
    assign req_ready = (state == LAUNCH) ? NUM_REQ'(1) << grant : '0;
    assign busy = state != IDLE;
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            win = req_valid[idx] ? idx : win;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            ss_n        <= '1;
            eng_start   <= 1'b0;
            eng_tx_data <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_id      <= '0;
            rsp_err     <= 1'b0;
            cnt         <= '0;
            last_q      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            eng_start <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    grant  <= win;
                    rsp_id <= win;
                    ss_n   <= ~(NUM_REQ'(1) << win);
                    state  <= SELECT;
                end
                SELECT: begin
                    cnt   <= '0;
                    state <= LAUNCH;
                end
                LAUNCH: if (req_valid[grant]) begin
                    eng_tx_data <= req_data[{grant, 3'b000} +: 8];
                    last_q      <= req_last[grant];
                    eng_start   <= 1'b1;
                    cnt         <= '0;
                    state       <= WAIT;
                end else if (to) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_data  <= '0;
                    ss_n      <= '1;
                    state     <= RELEASE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WAIT: if (eng_done) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= eng_rx_data;
                    rsp_err   <= 1'b0;
                    cnt       <= '0;
                    ss_n      <= last_q ? '1 : ss_n;
                    state     <= last_q ? RELEASE : LAUNCH;
                end else if (to) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_data  <= '0;
                    ss_n      <= '1;
                    state     <= RELEASE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RELEASE: begin
                    ptr   <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed stimulus with a response scoreboard and a behavioural SPI engine
module tb_spi_arbiter;
    logic        clk = 0;
    logic        reset;
    logic [3:0]  req_valid, req_last, req_ready, ss_n;
    logic [31:0] req_data;
    logic        rsp_valid, rsp_err, eng_start, eng_done, busy;
    logic [7:0]  rsp_data, eng_tx_data, eng_rx_data;
    logic [1:0]  rsp_id;

    typedef struct {logic [1:0] id; logic [7:0] data; logic err;} rsp_t;
    rsp_t exp_q[$];
    logic [7:0] exp_tx[$];
    int n_chk = 0, n_fail = 0;
    int eng_lat = 8;
    bit eng_en = 1;

    spi_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .ss_n(ss_n),
        .eng_start(eng_start), .eng_tx_data(eng_tx_data), .eng_done(eng_done),
        .eng_rx_data(eng_rx_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Engine model: answers each byte with tx ^ 0x99 after eng_lat cycles (unless disabled)
    initial begin
        eng_done = 0;
        eng_rx_data = 0;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1) begin
                if (exp_tx.size() == 0) chk("unexpected eng_start", 1, 0);
                else chk("eng_tx_data", eng_tx_data, exp_tx.pop_front());
                if (eng_en) begin
                    repeat (eng_lat - 1) @(negedge clk);
                    eng_done = 1;
                    eng_rx_data = eng_tx_data ^ 8'h99;
                    @(negedge clk);
                    eng_done = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected rsp_valid", 1, 0);
            else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err", rsp_err, e.err);
            end
        end
    end

    task automatic expect_rsp(input logic [1:0] id, input logic [7:0] d, input logic e);
        exp_q.push_back('{id, d, e});
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic l);
        int n = 0;
        @(negedge clk);
        req_valid[id] = 1;
        req_data[8*id +: 8] = d;
        req_last[id] = l;
        while (req_ready[id] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("handshake timeout", id, 32'hFF);
            req_valid[id] = 0;
            return;
        end
        @(posedge clk);
        exp_tx.push_back(d);
        #1 req_valid[id] = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) chk("idle timeout", 1, 0);
    endtask

    initial begin
        reset = 1;
        req_valid = 0;
        req_last = 0;
        req_data = 0;
        repeat (3) @(negedge clk);
        chk("reset ss_n", ss_n, 4'hF);
        chk("reset busy", busy, 0);
        chk("reset eng_start", eng_start, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset req_ready", req_ready, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset eng_tx_data", eng_tx_data, 0);
        reset = 0;

        // single requester
        expect_rsp(2, 8'h3C, 0);
        send(2, 8'hA5, 1);
        chk("single ss_n", ss_n, 4'b1011);
        wait_idle();
        chk("single ss_n after", ss_n, 4'hF);

        // burst lock with competing requester 1
        expect_rsp(0, 8'h88, 0);
        expect_rsp(0, 8'hBB, 0);
        expect_rsp(0, 8'hAA, 0);
        expect_rsp(1, 8'hDD, 0);
        fork
            begin
                send(0, 8'h11, 0);
                chk("burst ss_n b0", ss_n, 4'b1110);
                send(0, 8'h22, 0);
                chk("burst ss_n b1", ss_n, 4'b1110);
                send(0, 8'h33, 1);
                chk("burst ss_n b2", ss_n, 4'b1110);
            end
            send(1, 8'h44, 1);
            begin : gap_mon
                int k, gap;
                k = 0;
                while (ss_n[0] !== 1'b0 && k < 100) begin @(negedge clk); k++; end
                k = 0;
                while (ss_n[0] !== 1'b1 && k < 200) begin @(negedge clk); k++; end
                gap = 0;
                while (ss_n === 4'hF && gap < 50) begin @(negedge clk); gap++; end
                chk("burst gap>=2", gap >= 2, 1);
                chk("burst next grant ss_n", ss_n, 4'b1101);
            end
        join
        wait_idle();

        // round-robin from reset, faster engine
        eng_lat = 3;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        expect_rsp(0, 8'h98, 0);
        expect_rsp(1, 8'h9B, 0);
        expect_rsp(2, 8'h9A, 0);
        expect_rsp(3, 8'h9D, 0);
        fork
            send(0, 8'h01, 1);
            send(1, 8'h02, 1);
            send(2, 8'h03, 1);
            send(3, 8'h04, 1);
        join
        wait_idle();
        chk("rr ptr wrap", dut.ptr, 0);
        expect_rsp(0, 8'h9C, 0);
        send(0, 8'h05, 1);
        wait_idle();

        // engine timeout: error on the 8th WAIT edge
        eng_en = 0;
        expect_rsp(3, 8'h00, 1);
        send(3, 8'h77, 1);
        repeat (8) @(negedge clk);
        chk("eto rsp_valid early", rsp_valid, 0);
        @(negedge clk);
        chk("eto rsp_valid", rsp_valid, 1);
        chk("eto ss_n", ss_n, 4'hF);
        @(negedge clk);
        chk("eto busy", busy, 0);
        eng_en = 1;
        wait_idle();

        // requester stall after a non-last byte, then requester 1 granted
        expect_rsp(0, 8'hC3, 0);
        expect_rsp(0, 8'h00, 1);
        expect_rsp(1, 8'hFF, 0);
        fork
            send(0, 8'h5A, 0);
            send(1, 8'h66, 1);
        join
        wait_idle();

        // mid-burst reset: late eng_done must not produce a response
        eng_lat = 8;
        send(2, 8'h12, 1);
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("mrst ss_n", ss_n, 4'hF);
        chk("mrst busy", busy, 0);
        chk("mrst rsp_valid", rsp_valid, 0);
        chk("mrst eng_start", eng_start, 0);
        reset = 0;
        repeat (12) @(negedge clk);
        chk("mrst busy after", busy, 0);

        chk("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
